// File: rtl/game_state_pkg.sv
// game_state_pkg: shared game-state encoding and keycode bit indices for the game-flow and movement blocks
package game_state_pkg;
    typedef enum logic [1:0] {
        MENU     = 2'd0,
        PLAYING  = 2'd1,
        PAUSED   = 2'd2,
        GAMEOVER = 2'd3
    } state_t;
    localparam int KEY_START   = 0;
    localparam int KEY_GRAVITY = 1;
    localparam int KEY_PAUSE   = 2;
    localparam int KEY_D       = 5;
    localparam int KEY_W       = 6;
    localparam int KEY_A       = 7;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/key_edge_det.sv
// key_edge_det: per-bit rising-edge detector; clk/rst clock and sync reset, i_key in, o_rise = i_key & ~previous i_key
module key_edge_det #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_key,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_prev;
    always_ff @(posedge clk)
        r_prev <= rst ? '0 : i_key;
    assign o_rise = i_key & ~r_prev;
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-flow FSM tracking lives/level and driving the die/respawn strobe, one update per frame.
//   frame_clk/Reset: frame clock, sync active-high reset; keycode: key bitmask (Enter start, P pause used here);
//   hazard_hit/goal_reached: collision flags; outputs: state, die, lives, level, level_up pulse, win.
module game_state_ctrl
    import game_state_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int RESPAWN_FRAMES  = 30,
    parameter int MAX_LEVEL       = 4,
    parameter int GAMEOVER_FRAMES = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       hazard_hit,
    input  logic       goal_reached,
    output logic [1:0] current_state_out,
    output logic       die,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic       level_up,
    output logic       win
);
    localparam int          CW       = $clog2(max2(RESPAWN_FRAMES, GAMEOVER_FRAMES) + 1);
    localparam logic [2:0]  LAST_LVL = 3'(MAX_LEVEL - 1);
    localparam logic [1:0]  LIVES0   = 2'(LIVES_INIT);

    state_t          r_state, w_state;
    logic            r_die, w_die;
    logic [1:0]      r_lives, w_lives;
    logic [2:0]      r_level, w_level;
    logic            r_level_up, w_level_up;
    logic            r_win, w_win;
    logic [CW-1:0]   r_rcnt, w_rcnt;
    logic [CW-1:0]   r_gcnt, w_gcnt;
    logic [7:0]      w_rise;
    logic            w_start, w_pause;
    logic            w_unused;

    key_edge_det #(.W(8)) u_keys (
        .clk    (frame_clk),
        .rst    (Reset),
        .i_key  (keycode),
        .o_rise (w_rise)
    );

    assign w_start  = w_rise[KEY_START];
    assign w_pause  = w_rise[KEY_PAUSE];
    assign w_unused = &{1'b0, w_rise[7:3], w_rise[1]};

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= MENU;
            r_die      <= 1'b0;
            r_lives    <= LIVES0;
            r_level    <= '0;
            r_level_up <= 1'b0;
            r_win      <= 1'b0;
            r_rcnt     <= '0;
            r_gcnt     <= '0;
        end else begin
            r_state    <= w_state;
            r_die      <= w_die;
            r_lives    <= w_lives;
            r_level    <= w_level;
            r_level_up <= w_level_up;
            r_win      <= w_win;
            r_rcnt     <= w_rcnt;
            r_gcnt     <= w_gcnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_die      = r_die;
        w_lives    = r_lives;
        w_level    = r_level;
        w_level_up = 1'b0;
        w_win      = r_win;
        w_rcnt     = r_rcnt;
        w_gcnt     = r_gcnt;
        case (r_state)
            MENU: if (w_start) begin
                w_state = PLAYING;
                w_lives = LIVES0;
                w_level = '0;
                w_win   = 1'b0;
                w_die   = 1'b1;
                w_rcnt  = '0;
            end
            PLAYING: if (r_rcnt != '0) begin
                // respawn in progress: flags and keys are ignored until die drops
                w_die  = 1'b1;
                w_rcnt = r_rcnt - 1'b1;
            end else if (hazard_hit) begin
                w_die = 1'b1;
                if (r_lives > 2'd1) begin
                    w_lives = r_lives - 2'd1;
                    w_rcnt  = CW'(RESPAWN_FRAMES - 1);
                end else begin
                    w_lives = 2'd0;
                    w_win   = 1'b0;
                    w_state = GAMEOVER;
                    w_gcnt  = CW'(GAMEOVER_FRAMES);
                end
            end else if (goal_reached) begin
                w_die      = 1'b1;
                w_level_up = 1'b1;
                if (r_level < LAST_LVL) begin
                    w_level = r_level + 3'd1;
                end else begin
                    w_win   = 1'b1;
                    w_state = GAMEOVER;
                    w_gcnt  = CW'(GAMEOVER_FRAMES);
                end
            end else begin
                w_die   = 1'b0;
                w_state = w_pause ? PAUSED : PLAYING;
            end
            PAUSED: w_state = w_pause ? PLAYING : PAUSED;
            GAMEOVER: begin
                w_die = 1'b1;
                // start only counts once the lockout has fully expired; earlier presses are discarded
                if (r_gcnt != '0) begin
                    w_gcnt = r_gcnt - 1'b1;
                end else if (w_start) begin
                    w_state = MENU;
                    w_die   = 1'b0;
                end
            end
            default: w_state = MENU;
        endcase
    end

    assign current_state_out = r_state;
    assign die               = r_die;
    assign lives             = r_lives;
    assign level             = r_level;
    assign level_up          = r_level_up;
    assign win               = r_win;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scoreboard bench for game_state_ctrl
module tb_game_state_ctrl;
    localparam logic [1:0] S_MENU = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       hazard_hit;
    logic       goal_reached;
    logic [1:0] current_state_out;
    logic       die;
    logic [1:0] lives;
    logic [2:0] level;
    logic       level_up;
    logic       win;

    typedef struct {
        logic [1:0] st;
        logic       d;
        logic [1:0] lv;
        logic [2:0] lvl;
        logic       lu;
        logic       w;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    game_state_ctrl dut (
        .frame_clk         (frame_clk),
        .Reset             (Reset),
        .keycode           (keycode),
        .hazard_hit        (hazard_hit),
        .goal_reached      (goal_reached),
        .current_state_out (current_state_out),
        .die               (die),
        .lives             (lives),
        .level             (level),
        .level_up          (level_up),
        .win               (win)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", tag, fld, act, exp, $time);
        end
    endtask

    task automatic f(input logic r, input logic [7:0] k, input logic h, input logic g,
                     input logic [1:0] st, input logic d, input logic [1:0] lv,
                     input logic [2:0] lvl, input logic lu, input logic w, input string tag);
        exp_t e;
        @(negedge frame_clk);
        Reset        = r;
        keycode      = k;
        hazard_hit   = h;
        goal_reached = g;
        e.st  = st;
        e.d   = d;
        e.lv  = lv;
        e.lvl = lvl;
        e.lu  = lu;
        e.w   = w;
        e.tag = tag;
        q.push_back(e);
    endtask

    always @(posedge frame_clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk(m_e.tag, "state",    8'(current_state_out), 8'(m_e.st));
            chk(m_e.tag, "die",      8'(die),               8'(m_e.d));
            chk(m_e.tag, "lives",    8'(lives),             8'(m_e.lv));
            chk(m_e.tag, "level",    8'(level),             8'(m_e.lvl));
            chk(m_e.tag, "level_up", 8'(level_up),          8'(m_e.lu));
            chk(m_e.tag, "win",      8'(win),               8'(m_e.w));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset        = 1'b1;
        keycode      = 8'h00;
        hazard_hit   = 1'b0;
        goal_reached = 1'b0;
        f(1, 8'h00, 0, 0, S_MENU, 0, 3, 0, 0, 0, "reset");
        f(1, 8'h00, 0, 0, S_MENU, 0, 3, 0, 0, 0, "reset");
        f(0, 8'h00, 0, 0, S_MENU, 0, 3, 0, 0, 0, "menu_idle");
        f(0, 8'h01, 0, 0, S_PLAY, 1, 3, 0, 0, 0, "start");
        f(0, 8'h01, 0, 0, S_PLAY, 0, 3, 0, 0, 0, "start_held");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 0, 0, 0, "playing");
        for (int l = 0; l < 3; l++) begin
            f(0, 8'h00, 0, 1, S_PLAY, 1, 3, 3'(l + 1), 1, 0, "goal");
            f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 3'(l + 1), 0, 0, "goal_after");
        end
        f(0, 8'h04, 0, 0, S_PAUSE, 0, 3, 3, 0, 0, "pause");
        for (int i = 1; i < 10; i++)
            f(0, 8'h04, (i == 5), 0, S_PAUSE, 0, 3, 3, 0, 0, "pause_held");
        f(0, 8'h00, 0, 0, S_PAUSE, 0, 3, 3, 0, 0, "pause_release");
        f(0, 8'h04, 0, 0, S_PLAY, 0, 3, 3, 0, 0, "resume");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 3, 0, 0, "resumed");
        f(0, 8'h00, 1, 0, S_PLAY, 1, 2, 3, 0, 0, "hit1");
        for (int i = 0; i < 29; i++)
            f(0, 8'h00, (i == 5), (i == 10), S_PLAY, 1, 2, 3, 0, 0, "respawn1");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 2, 3, 0, 0, "respawn1_end");
        f(0, 8'h04, 1, 0, S_PLAY, 1, 1, 3, 0, 0, "hit2_pause_drop");
        for (int i = 0; i < 29; i++)
            f(0, (i == 0) ? 8'h04 : 8'h00, 0, 0, S_PLAY, 1, 1, 3, 0, 0, "respawn2");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 1, 3, 0, 0, "respawn2_end");
        f(0, 8'h00, 1, 1, S_OVER, 1, 0, 3, 0, 0, "hit3_over");
        for (int k = 1; k < 120; k++)
            f(0, (k == 50) ? 8'h01 : 8'h00, 0, 0, S_OVER, 1, 0, 3, 0, 0, "gameover_wait");
        f(0, 8'h01, 0, 0, S_OVER, 1, 0, 3, 0, 0, "start_early");
        f(0, 8'h01, 0, 0, S_OVER, 1, 0, 3, 0, 0, "start_held_over");
        f(0, 8'h00, 0, 0, S_OVER, 1, 0, 3, 0, 0, "release_over");
        f(0, 8'h01, 0, 0, S_MENU, 0, 0, 3, 0, 0, "to_menu");
        f(0, 8'h00, 0, 0, S_MENU, 0, 0, 3, 0, 0, "menu");
        f(0, 8'h01, 0, 0, S_PLAY, 1, 3, 0, 0, 0, "restart");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 0, 0, 0, "restart_idle");
        for (int l = 0; l < 3; l++) begin
            f(0, 8'h00, 0, 1, S_PLAY, 1, 3, 3'(l + 1), 1, 0, "goal2");
            f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 3'(l + 1), 0, 0, "goal2_after");
        end
        f(0, 8'h00, 0, 1, S_OVER, 1, 3, 3, 1, 1, "win");
        f(0, 8'h00, 0, 1, S_OVER, 1, 3, 3, 0, 1, "win_hold");
        f(1, 8'h00, 0, 0, S_MENU, 0, 3, 0, 0, 0, "reset2");
        f(0, 8'h01, 0, 0, S_PLAY, 1, 3, 0, 0, 0, "start3");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 0, 0, 0, "start3_idle");
        f(0, 8'h00, 1, 0, S_PLAY, 1, 2, 0, 0, 0, "hit4");
        for (int i = 0; i < 5; i++)
            f(0, 8'h00, 0, 0, S_PLAY, 1, 2, 0, 0, 0, "respawn3");
        f(1, 8'h04, 1, 0, S_MENU, 0, 3, 0, 0, 0, "reset_mid_respawn");
        f(0, 8'h00, 0, 0, S_MENU, 0, 3, 0, 0, 0, "after_reset");
        f(0, 8'h01, 0, 0, S_PLAY, 1, 3, 0, 0, 0, "start4");
        f(0, 8'h00, 0, 0, S_PLAY, 0, 3, 0, 0, 0, "rcnt_cleared");
        repeat (3) @(posedge frame_clk);
        #2;
        chk("end", "queue_empty", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
